// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU function codes, writeback selects and pipeline control bundle
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_GEZ = 6'b111001,
    ALU_GTZ = 6'b111111
  } alu_fun_e;
  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC  = 2'd2
  } mem_to_reg_e;
  typedef struct packed {
    logic valid;
    logic memrd;
    logic memwr;
    logic regwr;
  } ctl_t;
  localparam ctl_t CTL_BUBBLE = '0;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: one operand forwarding select (src reg, latched data, EX/MEM and MEM/WB ports -> fwd), EX/MEM wins, r0 never forwarded
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   data,
  input  logic              exm_regwr,
  input  logic [REG_AW-1:0] exm_dst,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_regwr,
  input  logic [REG_AW-1:0] mwb_dst,
  input  logic [XLEN-1:0]   mwb_data,
  output logic [XLEN-1:0]   fwd
);
  always_comb
    fwd = (exm_regwr && exm_dst != '0 && exm_dst == src) ? exm_result :
          (mwb_regwr && mwb_dst != '0 && mwb_dst == src) ? mwb_data : data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with operand forwarding, ALU A/B/fun/sign drive, load-use stall, flush and hold
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic [XLEN-1:0]   id_rs_data_i,
  input  logic [XLEN-1:0]   id_rt_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_shamt_i,
  input  logic              id_alusrc1_i,
  input  logic              id_alusrc2_i,
  input  logic [5:0]        id_alufun_i,
  input  logic              id_sign_i,
  input  logic              id_memrd_i,
  input  logic              id_memwr_i,
  input  logic              id_regwr_i,
  input  logic [1:0]        id_memtoreg_i,
  input  logic              exm_regwr_i,
  input  logic [REG_AW-1:0] exm_dst_i,
  input  logic [XLEN-1:0]   exm_result_i,
  input  logic              mwb_regwr_i,
  input  logic [REG_AW-1:0] mwb_dst_i,
  input  logic [XLEN-1:0]   mwb_data_i,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [5:0]        alu_fun_o,
  output logic              alu_sign_o,
  output logic [XLEN-1:0]   ex_store_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic              ex_memrd_o,
  output logic              ex_memwr_o,
  output logic              ex_regwr_o,
  output logic [1:0]        ex_memtoreg_o,
  output logic              stall_o
);
  ctl_t              ctl;
  logic [REG_AW-1:0] rs, rt, dst;
  logic [XLEN-1:0]   rs_data, rt_data, imm, fwd_rs, fwd_rt;
  logic [4:0]        shamt;
  logic              alusrc1, alusrc2, sign;
  logic [5:0]        alufun;
  logic [1:0]        memtoreg;
  always_ff @(posedge clk)
    if (reset) begin
      ctl      <= CTL_BUBBLE;
      rs       <= '0;
      rt       <= '0;
      dst      <= '0;
      rs_data  <= '0;
      rt_data  <= '0;
      imm      <= '0;
      shamt    <= '0;
      alusrc1  <= 1'b0;
      alusrc2  <= 1'b0;
      alufun   <= ALU_ADD;
      sign     <= 1'b0;
      memtoreg <= MTR_ALU;
    end else if (flush_i || (!hold_i && stall_o))
      ctl <= CTL_BUBBLE;
    else if (!hold_i) begin
      ctl      <= '{valid: id_valid_i, memrd: id_memrd_i, memwr: id_memwr_i, regwr: id_regwr_i};
      rs       <= id_rs_i;
      rt       <= id_rt_i;
      dst      <= id_dst_i;
      rs_data  <= id_rs_data_i;
      rt_data  <= id_rt_data_i;
      imm      <= id_imm_i;
      shamt    <= id_shamt_i;
      alusrc1  <= id_alusrc1_i;
      alusrc2  <= id_alusrc2_i;
      alufun   <= id_alufun_i;
      sign     <= id_sign_i;
      memtoreg <= id_memtoreg_i;
    end
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs (
    .src(rs), .data(rs_data),
    .exm_regwr(exm_regwr_i), .exm_dst(exm_dst_i), .exm_result(exm_result_i),
    .mwb_regwr(mwb_regwr_i), .mwb_dst(mwb_dst_i), .mwb_data(mwb_data_i),
    .fwd(fwd_rs)
  );
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rt (
    .src(rt), .data(rt_data),
    .exm_regwr(exm_regwr_i), .exm_dst(exm_dst_i), .exm_result(exm_result_i),
    .mwb_regwr(mwb_regwr_i), .mwb_dst(mwb_dst_i), .mwb_data(mwb_data_i),
    .fwd(fwd_rt)
  );
  always_comb begin
    alu_a_o       = alusrc1 ? {{(XLEN-5){1'b0}}, shamt} : fwd_rs;
    alu_b_o       = alusrc2 ? imm : fwd_rt;
    alu_fun_o     = alufun;
    alu_sign_o    = sign;
    ex_store_o    = fwd_rt;
    ex_dst_o      = dst;
    ex_memrd_o    = ctl.memrd;
    ex_memwr_o    = ctl.memwr;
    ex_regwr_o    = ctl.regwr;
    ex_memtoreg_o = memtoreg;
    stall_o       = !reset && !flush_i && ctl.valid && ctl.memrd && ctl.regwr && dst != '0 &&
                    id_valid_i && (dst == id_rs_i || dst == id_rt_i);
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage forwarding, load-use stall, flush, hold and reset
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic        clk = 0, reset = 1, hold_i = 0, flush_i = 0, id_valid_i = 0;
  logic [4:0]  id_rs_i = 0, id_rt_i = 0, id_dst_i = 0, id_shamt_i = 0;
  logic [31:0] id_rs_data_i = 0, id_rt_data_i = 0, id_imm_i = 0;
  logic        id_alusrc1_i = 0, id_alusrc2_i = 0, id_sign_i = 0;
  logic [5:0]  id_alufun_i = 0;
  logic        id_memrd_i = 0, id_memwr_i = 0, id_regwr_i = 0;
  logic [1:0]  id_memtoreg_i = 0;
  logic        exm_regwr_i = 0, mwb_regwr_i = 0;
  logic [4:0]  exm_dst_i = 0, mwb_dst_i = 0;
  logic [31:0] exm_result_i = 0, mwb_data_i = 0;
  logic [31:0] alu_a_o, alu_b_o, ex_store_o;
  logic [5:0]  alu_fun_o;
  logic        alu_sign_o, ex_memrd_o, ex_memwr_o, ex_regwr_o, stall_o;
  logic [4:0]  ex_dst_o;
  logic [1:0]  ex_memtoreg_o;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] a, b, st;
    logic [5:0]  fun;
    logic        regwr, memrd, bub;
    logic [4:0]  dst;
  } exp_t;
  exp_t q[$];
  id_ex_stage dut (
    .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_dst_i(id_dst_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_shamt_i(id_shamt_i), .id_alusrc1_i(id_alusrc1_i), .id_alusrc2_i(id_alusrc2_i),
    .id_alufun_i(id_alufun_i), .id_sign_i(id_sign_i), .id_memrd_i(id_memrd_i),
    .id_memwr_i(id_memwr_i), .id_regwr_i(id_regwr_i), .id_memtoreg_i(id_memtoreg_i),
    .exm_regwr_i(exm_regwr_i), .exm_dst_i(exm_dst_i), .exm_result_i(exm_result_i),
    .mwb_regwr_i(mwb_regwr_i), .mwb_dst_i(mwb_dst_i), .mwb_data_i(mwb_data_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_fun_o(alu_fun_o), .alu_sign_o(alu_sign_o),
    .ex_store_o(ex_store_o), .ex_dst_o(ex_dst_o), .ex_memrd_o(ex_memrd_o),
    .ex_memwr_o(ex_memwr_o), .ex_regwr_o(ex_regwr_o), .ex_memtoreg_o(ex_memtoreg_o),
    .stall_o(stall_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [31:0] a, b, st, input logic [5:0] fun,
                      input logic regwr, memrd, input logic [4:0] dst);
    q.push_back('{a: a, b: b, st: st, fun: fun, regwr: regwr, memrd: memrd, bub: 1'b0, dst: dst});
  endtask
  task automatic push_bubble();
    q.push_back('{a: 0, b: 0, st: 0, fun: 0, regwr: 0, memrd: 0, bub: 1'b1, dst: 0});
  endtask
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".q"}, q.size(), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".regwr"}, ex_regwr_o, e.regwr);
      chk({tag, ".memrd"}, ex_memrd_o, e.memrd);
      if (e.bub)
        chk({tag, ".memwr"}, ex_memwr_o, 0);
      else begin
        chk({tag, ".a"}, alu_a_o, e.a);
        chk({tag, ".b"}, alu_b_o, e.b);
        chk({tag, ".st"}, ex_store_o, e.st);
        chk({tag, ".fun"}, alu_fun_o, e.fun);
        chk({tag, ".dst"}, ex_dst_o, e.dst);
      end
    end
  endtask
  task automatic id_op(input logic [4:0] rs, rt, dst, input logic [31:0] rsd, rtd, imm,
                       input logic [5:0] fun, input logic memrd, regwr, src1, src2,
                       input logic [4:0] sh);
    id_valid_i = 1; id_rs_i = rs; id_rt_i = rt; id_dst_i = dst;
    id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm; id_alufun_i = fun;
    id_memrd_i = memrd; id_memwr_i = 0; id_regwr_i = regwr; id_memtoreg_i = {1'b0, memrd};
    id_alusrc1_i = src1; id_alusrc2_i = src2; id_shamt_i = sh; id_sign_i = 0;
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst.a", alu_a_o, 0);
    chk("rst.b", alu_b_o, 0);
    chk("rst.fun", alu_fun_o, 0);
    chk("rst.st", ex_store_o, 0);
    chk("rst.regwr", ex_regwr_o, 0);
    chk("rst.memrd", ex_memrd_o, 0);
    chk("rst.stall", stall_o, 0);
    reset = 0;
    id_op(3, 4, 9, 5, 7, 0, ALU_ADD, 0, 1, 0, 0, 0);
    push(5, 7, 7, ALU_ADD, 1, 0, 9);
    cyc();
    check_out("add");
    exm_regwr_i = 1; exm_dst_i = 3; exm_result_i = 32'h10;
    mwb_regwr_i = 1; mwb_dst_i = 3; mwb_data_i = 32'h20;
    #1 chk("fwd_exm_wins", alu_a_o, 32'h10);
    exm_dst_i = 0;
    #1 chk("fwd_exm_r0", alu_a_o, 32'h20);
    mwb_dst_i = 4;
    #1 chk("fwd_rt_b", alu_b_o, 32'h20);
    chk("fwd_rt_st", ex_store_o, 32'h20);
    chk("fwd_rs_none", alu_a_o, 5);
    exm_regwr_i = 0; mwb_regwr_i = 0; exm_dst_i = 0; mwb_dst_i = 0;
    id_op(1, 0, 8, 100, 0, 4, ALU_ADD, 1, 1, 0, 1, 0);
    push(100, 4, 0, ALU_ADD, 1, 1, 8);
    cyc();
    check_out("lw");
    id_op(8, 2, 10, 0, 33, 0, ALU_ADD, 0, 1, 0, 0, 0);
    #1 chk("stall_lu", stall_o, 1);
    push_bubble();
    cyc();
    check_out("lu_bub");
    chk("stall_once", stall_o, 0);
    id_rs_data_i = 55;
    push(55, 33, 33, ALU_ADD, 1, 0, 10);
    cyc();
    check_out("add_after");
    chk("stall_after", stall_o, 0);
    id_op(1, 0, 8, 100, 0, 4, ALU_ADD, 1, 1, 0, 1, 0);
    push(100, 4, 0, ALU_ADD, 1, 1, 8);
    cyc();
    check_out("lw_f");
    id_op(8, 2, 10, 0, 33, 0, ALU_ADD, 0, 1, 0, 0, 0);
    flush_i = 1;
    #1 chk("stall_flush", stall_o, 0);
    push_bubble();
    cyc();
    check_out("flush");
    flush_i = 0;
    id_op(1, 0, 12, 7, 0, 1, ALU_ADD, 1, 1, 0, 1, 0);
    push(7, 1, 0, ALU_ADD, 1, 1, 12);
    cyc();
    check_out("lw_h");
    hold_i = 1;
    id_op(12, 0, 13, 9, 9, 0, ALU_SUB, 0, 1, 0, 0, 0);
    #1 chk("stall_h", stall_o, 1);
    push(7, 1, 0, ALU_ADD, 1, 1, 12);
    cyc();
    check_out("hold");
    chk("stall_held", stall_o, 1);
    exm_regwr_i = 1; exm_dst_i = 1; exm_result_i = 32'h99;
    #1 chk("hold_fwd", alu_a_o, 32'h99);
    exm_regwr_i = 0; exm_dst_i = 0;
    hold_i = 0;
    push_bubble();
    cyc();
    check_out("hold_rel");
    chk("stall_rel", stall_o, 0);
    push(9, 9, 9, ALU_SUB, 1, 0, 13);
    cyc();
    check_out("sub");
    id_op(1, 0, 8, 100, 0, 4, ALU_ADD, 1, 1, 0, 1, 0);
    push(100, 4, 0, ALU_ADD, 1, 1, 8);
    cyc();
    check_out("lw_r");
    id_op(8, 2, 10, 0, 33, 0, ALU_ADD, 0, 1, 0, 0, 0);
    #1 chk("stall_r", stall_o, 1);
    reset = 1;
    #1 chk("stall_rst", stall_o, 0);
    push_bubble();
    cyc();
    check_out("rst_mid");
    reset = 0;
    #1 chk("stall_post_rst", stall_o, 0);
    id_op(0, 5, 6, 0, 32'hFF, 0, ALU_SLL, 0, 1, 1, 0, 4);
    mwb_regwr_i = 1; mwb_dst_i = 5; mwb_data_i = 3;
    push(4, 3, 3, ALU_SLL, 1, 0, 6);
    cyc();
    check_out("sll");
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
